dmem_mmio_bridge: RTL and testbench

- Sits directly downstream of the core's data-memory port and consumes dmemAddr, dmemWdata, dmemSize and dmemWen.
- Returns dmemRdata combinationally in the same cycle, as the M stage requires.
- Decodes each access into one of three targets: a byte-addressable data RAM, a memory-mapped TX FIFO with a valid/ready drain port, and cycle-counter and tohost/halt registers used by the simulation bench.

---
 rtl/dmem_mmio_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_bridge.sv
// Data-memory bridge: byte-addressable RAM, TX FIFO with valid/ready drain, and bench MMIO.
// Define DMEM_CYCLE_CNT_EN to build the 64-bit cycle counter and its CYCHI shadow register.
module dmem_mmio_bridge #(
  parameter int unsigned RAM_BYTES = 65536,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        halt,
  output logic [31:0] haltCode,
  output logic [1:0]  errSticky
);

  localparam int unsigned RamWords = RAM_BYTES / 4;
  localparam int unsigned RamAw    = $clog2(RamWords);
  localparam int unsigned PtrW     = $clog2(TX_DEPTH);
  localparam logic [31:0] RamMask  = 32'(RAM_BYTES - 1);
  localparam logic [PtrW:0] DepthVal = (PtrW + 1)'(TX_DEPTH);

  localparam logic [2:0] OffTxData = 3'd0;
  localparam logic [2:0] OffTxStat = 3'd1;
  localparam logic [2:0] OffCycLo  = 3'd2;
  localparam logic [2:0] OffCycHi  = 3'd3;
  localparam logic [2:0] OffToHost = 3'd4;

  // ---------------------------------------------------------------------------
  // Address decode and access qualification
  // ---------------------------------------------------------------------------
  logic ramHit, mmioHit, mmioSel, mapped;
  logic sizeByte, sizeHalf, sizeWord;
  logic misaligned, accessOk, storeEn;
  logic [2:0] mmioOff;

  assign ramHit   = (dmemAddr & ~RamMask) == RAM_BASE;
  assign mmioHit  = dmemAddr[31:5] == MMIO_BASE[31:5];
  assign mmioSel  = mmioHit && !ramHit;
  assign mapped   = ramHit || mmioHit;
  assign mmioOff  = dmemAddr[4:2];

  assign sizeByte = dmemSize[1:0] == 2'b00;
  assign sizeHalf = dmemSize[1:0] == 2'b01;
  assign sizeWord = dmemSize[1:0] == 2'b10;

  assign misaligned = (sizeHalf && dmemAddr[0]) || (sizeWord && (dmemAddr[1:0] != 2'b00));
  // Size encoding 2'b11 is not a legal RV access: it neither reads nor writes.
  assign accessOk   = !misaligned && (dmemSize[1:0] != 2'b11);
  assign storeEn    = dmemWen && !halt;

  logic mmioWordOk;
  assign mmioWordOk = mmioSel && sizeWord && accessOk;

  // ---------------------------------------------------------------------------
  // Data RAM: word array with byte-lane enables, asynchronous read
  // ---------------------------------------------------------------------------
  logic [31:0]      ram [RamWords];
  logic [RamAw-1:0] ramIdx;
  logic [3:0]       byteEn;
  logic [31:0]      wdLanes;
  logic             ramWe;
  logic [31:0]      ramWord;

  assign ramIdx = dmemAddr[RamAw+1:2];
  assign ramWe  = storeEn && ramHit && accessOk;

  always_comb begin
    byteEn = 4'b0000;
    case (dmemSize[1:0])
      2'b00:   byteEn = 4'b0001 << dmemAddr[1:0];
      2'b01:   byteEn = dmemAddr[1] ? 4'b1100 : 4'b0011;
      2'b10:   byteEn = 4'b1111;
      default: byteEn = 4'b0000;
    endcase
  end

  // Store data arrives right-aligned; replicate it so every enabled lane sees it.
  assign wdLanes = sizeByte ? {4{dmemWdata[7:0]}} :
                   sizeHalf ? {2{dmemWdata[15:0]}} : dmemWdata;

  always_ff @(posedge clk) begin
    if (ramWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) ram[ramIdx][8*b +: 8] <= wdLanes[8*b +: 8];
      end
    end
  end

  assign ramWord = ram[ramIdx];

  logic [31:0] laneWord;
  logic [15:0] laneHalf;
  logic [31:0] ramRdata;

  always_comb begin
    laneWord = ramWord >> {dmemAddr[1:0], 3'b000};
    laneHalf = dmemAddr[1] ? ramWord[31:16] : ramWord[15:0];
    case (dmemSize[1:0])
      2'b00:   ramRdata = dmemSize[2] ? {24'b0, laneWord[7:0]}
                                      : {{24{laneWord[7]}}, laneWord[7:0]};
      2'b01:   ramRdata = dmemSize[2] ? {16'b0, laneHalf}
                                      : {{16{laneHalf[15]}}, laneHalf};
      2'b10:   ramRdata = ramWord;
      default: ramRdata = 32'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // TX FIFO: ring buffer, pointers carry an extra wrap bit
  // ---------------------------------------------------------------------------
  logic [7:0]    fifoMem [TX_DEPTH];
  logic [PtrW:0] wrPtr, rdPtr, count;
  logic          fifoEmpty, fifoFull;
  logic          txPop, pushReq, pushOk, overflow;

  assign count     = wrPtr - rdPtr;
  assign fifoEmpty = count == '0;
  assign fifoFull  = count == DepthVal;
  assign txValid   = !fifoEmpty;
  assign txData    = fifoEmpty ? 8'h00 : fifoMem[rdPtr[PtrW-1:0]];
  assign txPop     = txValid && txReady;

  assign pushReq  = storeEn && mmioWordOk && (mmioOff == OffTxData);
  // When full, a same-cycle pop frees the slot being written.
  assign pushOk   = pushReq && (!fifoFull || txPop);
  assign overflow = pushReq && !pushOk;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (txPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) fifoMem[wrPtr[PtrW-1:0]] <= dmemWdata[7:0];
  end

  logic [31:0] txStat;
  assign txStat = {16'b0, 8'(count), 6'b0, fifoEmpty, fifoFull};

  // ---------------------------------------------------------------------------
  // Cycle counter and CYCHI shadow
  // ---------------------------------------------------------------------------
  logic [31:0] cycLo, cycHi;

`ifdef DMEM_CYCLE_CNT_EN
  logic [63:0] cycleCnt;
  logic [31:0] shadowHi;
  logic        cycLoRd;

  // Reading CYCLO snapshots the upper half so CYCLO/CYCHI form a coherent pair.
  assign cycLoRd = !dmemWen && mmioWordOk && (mmioOff == OffCycLo);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCnt <= '0;
      shadowHi <= '0;
    end else begin
      if (!halt)   cycleCnt <= cycleCnt + 64'd1;
      if (cycLoRd) shadowHi <= cycleCnt[63:32];
    end
  end

  assign cycLo = cycleCnt[31:0];
  assign cycHi = shadowHi;
`else
  assign cycLo = 32'b0;
  assign cycHi = 32'b0;
`endif

  // ---------------------------------------------------------------------------
  // MMIO read mux and load-data select
  // ---------------------------------------------------------------------------
  logic [31:0] mmioRdata;

  always_comb begin
    case (mmioOff)
      OffTxStat: mmioRdata = txStat;
      OffCycLo:  mmioRdata = cycLo;
      OffCycHi:  mmioRdata = cycHi;
      default:   mmioRdata = 32'b0;
    endcase
  end

  always_comb begin
    if (ramHit && accessOk)  dmemRdata = ramRdata;
    else if (mmioWordOk)     dmemRdata = mmioRdata;
    else                     dmemRdata = 32'b0;
  end

  // ---------------------------------------------------------------------------
  // Halt / tohost and sticky error flags
  // ---------------------------------------------------------------------------
  logic toHostWr;
  assign toHostWr = storeEn && mmioWordOk && (mmioOff == OffToHost);

  always_ff @(posedge clk) begin
    if (rst) begin
      halt      <= 1'b0;
      haltCode  <= 32'b0;
      errSticky <= 2'b00;
    end else begin
      if (toHostWr) begin
        halt     <= 1'b1;
        haltCode <= dmemWdata;
      end
      // Idle cycles on unmapped addresses must not raise a misalignment error.
      if (misaligned && (dmemWen || mapped)) errSticky[0] <= 1'b1;
      if (overflow)                          errSticky[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Self-checking bench for dmem_mmio_bridge: directed scenarios plus a randomized
// RAM/FIFO run against a byte-level reference model.
module tb_dmem_mmio_bridge;

`ifdef DMEM_CYCLE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  localparam logic [31:0] MmioBase = 32'h1000_0000;
  localparam logic [31:0] TxDataA  = MmioBase + 32'h00;
  localparam logic [31:0] TxStatA  = MmioBase + 32'h04;
  localparam logic [31:0] CycLoA   = MmioBase + 32'h08;
  localparam logic [31:0] CycHiA   = MmioBase + 32'h0C;
  localparam logic [31:0] ToHostA  = MmioBase + 32'h10;
  localparam logic [31:0] IdleA    = 32'h2000_0000;
  localparam int          Depth    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmemAddr, dmemWdata, dmemRdata, haltCode;
  logic [2:0]  dmemSize;
  logic        dmemWen, txValid, txReady, halt;
  logic [7:0]  txData;
  logic [1:0]  errSticky;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [7:0]      memM [int];
  logic [7:0]      fifoQ [$];
  logic [1:0]      errM;
  bit              haltM;
  longint unsigned cycM;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst)         cycM <= 0;
    else if (!haltM) cycM <= cycM + 1;
  end

  dmem_mmio_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .dmemAddr  (dmemAddr),
    .dmemWdata (dmemWdata),
    .dmemSize  (dmemSize),
    .dmemWen   (dmemWen),
    .dmemRdata (dmemRdata),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .halt      (halt),
    .haltCode  (haltCode),
    .errSticky (errSticky)
  );

  task automatic setIdle();
    dmemAddr  = IdleA;
    dmemWdata = 32'h0;
    dmemSize  = 3'b010;
    dmemWen   = 1'b0;
  endtask

  // One-cycle access: rdata sampled at the negedge, returns #1 after the edge.
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                        input logic wen, output logic [31:0] rd);
    dmemAddr  = a;
    dmemWdata = wd;
    dmemSize  = sz;
    dmemWen   = wen;
    @(negedge clk);
    rd = dmemRdata;
    @(posedge clk);
    #1;
    setIdle();
  endtask

  task automatic doReset();
    setIdle();
    txReady = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifoQ.delete();
    errM  = 2'b00;
    haltM = 1'b0;
  endtask

  function automatic int sizeBytes(input logic [2:0] sz);
    return (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] loadModel(input logic [31:0] a, input logic [2:0] sz);
    int n;
    logic [31:0] v;
    n = sizeBytes(sz);
    v = 32'h0;
    if ((a % n) != 0) return 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(memM[int'(a) + i]) << (8 * i));
    if (!sz[2] && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 1);
    return v;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    doReset();
    nChecks++; if (txValid !== 1'b0) begin nFails++; $display("FAIL reset_txValid: got %b expected 0", txValid); end
    nChecks++; if (txData !== 8'h00) begin nFails++; $display("FAIL reset_txData: got %h expected 00", txData); end
    nChecks++; if (halt !== 1'b0) begin nFails++; $display("FAIL reset_halt: got %b expected 0", halt); end
    nChecks++; if (haltCode !== 32'h0) begin nFails++; $display("FAIL reset_haltCode: got %h expected 0", haltCode); end
    nChecks++; if (errSticky !== 2'b00) begin nFails++; $display("FAIL reset_err: got %b expected 00", errSticky); end
    access(TxStatA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'h0000_0002) begin nFails++; $display("FAIL reset_txstat: got %h expected 00000002", rd); end
  endtask

  task automatic test_load_ext();
    logic [31:0] rd;
    logic [2:0]  szs [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] exps [5] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'h0000_20F1, 32'h0000_20F1,
                              32'h8040_20F1};
    access(32'h100, 32'h8040_20F1, 3'b010, 1'b1, rd);
    for (int i = 0; i < 5; i++) begin
      access(32'h100, 32'h0, szs[i], 1'b0, rd);
      nChecks++;
      if (rd !== exps[i]) begin
        nFails++; $display("FAIL load_ext[%0d]: got %h expected %h", i, rd, exps[i]);
      end
    end
    access(32'h103, 32'h0, 3'b000, 1'b0, rd);
    nChecks++; if (rd !== 32'hFFFF_FF80) begin nFails++; $display("FAIL lb_0x103: got %h expected ffffff80", rd); end
  endtask

  task automatic test_half_store();
    logic [31:0] rd;
    access(32'h100, 32'h1122_3344, 3'b010, 1'b1, rd);
    access(32'h102, 32'h0000_BEEF, 3'b001, 1'b1, rd);
    access(32'h100, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'hBEEF_3344) begin nFails++; $display("FAIL sh_merge: got %h expected beef3344", rd); end
    access(32'h101, 32'h0000_5555, 3'b001, 1'b1, rd);
    access(32'h100, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'hBEEF_3344) begin nFails++; $display("FAIL sh_misaligned: got %h expected beef3344", rd); end
    nChecks++; if (errSticky !== 2'b01) begin nFails++; $display("FAIL misalign_err: got %b expected 01", errSticky); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] rd;
    txReady = 1'b0;
    for (int i = 0; i < 9; i++) access(TxDataA, 32'h41 + i, 3'b010, 1'b1, rd);
    access(TxStatA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'h0000_0801) begin nFails++; $display("FAIL txstat_full: got %h expected 00000801", rd); end
    nChecks++; if (errSticky[1] !== 1'b1) begin nFails++; $display("FAIL overflow_err: got %b expected 1", errSticky[1]); end
    nChecks++; if (txData !== 8'h41) begin nFails++; $display("FAIL head_full: got %h expected 41", txData); end
    txReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nChecks++;
      if (txValid !== 1'b1 || txData !== 8'(8'h41 + i)) begin
        nFails++; $display("FAIL drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, txValid, txData, 8'(8'h41 + i));
      end
      @(posedge clk);
      #1;
    end
    txReady = 1'b0;
    nChecks++; if (txValid !== 1'b0) begin nFails++; $display("FAIL drained_empty: got %b expected 0", txValid); end
  endtask

  task automatic test_full_pop_push();
    logic [31:0] rd;
    doReset();
    for (int i = 0; i < 8; i++) access(TxDataA, 32'h61 + i, 3'b010, 1'b1, rd);
    txReady = 1'b1;
    access(TxDataA, 32'h5A, 3'b010, 1'b1, rd);
    txReady = 1'b0;
    access(TxStatA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'h0000_0801) begin nFails++; $display("FAIL pushpop_count: got %h expected 00000801", rd); end
    nChecks++; if (errSticky !== 2'b00) begin nFails++; $display("FAIL pushpop_err: got %b expected 00", errSticky); end
    nChecks++; if (txData !== 8'h62) begin nFails++; $display("FAIL pushpop_head: got %h expected 62", txData); end
  endtask

  task automatic test_counter();
    logic [31:0] rd;
    doReset();
    repeat (20) @(posedge clk);
    #1;
    access(CycLoA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== (CntEn ? 32'd20 : 32'd0)) begin nFails++; $display("FAIL cyclo_20: got %0d expected %0d", rd, CntEn ? 20 : 0); end
    access(CycHiA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("FAIL cychi: got %h expected 0", rd); end
  endtask

  task automatic test_halt();
    logic [31:0] rd, exp;
    access(32'h200, 32'h1234_5678, 3'b010, 1'b1, rd);
    access(ToHostA, 32'h1, 3'b010, 1'b1, rd);
    haltM = 1'b1;
    nChecks++; if (halt !== 1'b1 || haltCode !== 32'h1) begin nFails++; $display("FAIL halt_set: got %b/%h expected 1/00000001", halt, haltCode); end
    access(32'h200, 32'hDEAD, 3'b010, 1'b1, rd);
    access(ToHostA, 32'h2, 3'b010, 1'b1, rd);
    access(TxDataA, 32'h77, 3'b010, 1'b1, rd);
    access(32'h200, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== 32'h1234_5678) begin nFails++; $display("FAIL halt_store: got %h expected 12345678", rd); end
    nChecks++; if (haltCode !== 32'h1) begin nFails++; $display("FAIL halt_code2: got %h expected 00000001", haltCode); end
    nChecks++; if (txValid !== 1'b0) begin nFails++; $display("FAIL halt_push: got %b expected 0", txValid); end
    repeat (5) @(posedge clk);
    #1;
    exp = CntEn ? cycM[31:0] : 32'h0;
    access(CycLoA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== exp) begin nFails++; $display("FAIL cyc_frozen: got %0d expected %0d", rd, exp); end
    doReset();
    nChecks++; if (halt !== 1'b0 || errSticky !== 2'b00) begin nFails++; $display("FAIL rst_clear: got %b/%b expected 0/00", halt, errSticky); end
    repeat (3) @(posedge clk);
    #1;
    exp = CntEn ? cycM[31:0] : 32'h0;
    access(CycLoA, 32'h0, 3'b010, 1'b0, rd);
    nChecks++; if (rd !== exp) begin nFails++; $display("FAIL cyc_restart: got %0d expected %0d", rd, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp;
    logic [2:0]  sz;
    logic        wen, pop, isPush;
    int          op, n;
    doReset();
    for (int i = 0; i < 64; i++) begin
      wd = $urandom;
      access(32'h400 + 4 * i, wd, 3'b010, 1'b1, rd);
      for (int b = 0; b < 4; b++) memM[32'h400 + 4 * i + b] = wd[8*b +: 8];
    end
    for (int it = 0; it < 400; it++) begin
      op = $urandom_range(0, 9);
      txReady = 1'($urandom_range(0, 1));
      wd = $urandom;
      isPush = 1'b0;
      if (op <= 5) begin
        a   = 32'h400 + $urandom_range(0, 255);
        sz  = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
        wen = 1'($urandom_range(0, 1));
        exp = loadModel(a, sz);
      end else if (op <= 7) begin
        a = TxDataA; sz = 3'b010; wen = 1'b1; exp = 32'h0; isPush = 1'b1;
      end else if (op == 8) begin
        a = TxStatA; sz = 3'b010; wen = 1'b0;
        exp = {16'h0, 8'(fifoQ.size()), 6'h0, fifoQ.size() == 0, fifoQ.size() == Depth};
      end else begin
        a = 32'h3000_0000 + 4 * $urandom_range(0, 63); sz = 3'b010;
        wen = 1'($urandom_range(0, 1)); exp = 32'h0;
      end
      dmemAddr = a; dmemWdata = wd; dmemSize = sz; dmemWen = wen;
      @(negedge clk);
      nChecks++;
      if (dmemRdata !== exp) begin
        nFails++; $display("FAIL rand_rdata[%0d] a=%h sz=%b: got %h expected %h", it, a, sz, dmemRdata, exp);
      end
      nChecks++;
      if (txValid !== (fifoQ.size() != 0) || (fifoQ.size() != 0 && txData !== fifoQ[0])) begin
        nFails++; $display("FAIL rand_fifo[%0d]: got v=%b d=%h expected v=%b d=%h", it, txValid, txData,
                           fifoQ.size() != 0, (fifoQ.size() != 0) ? fifoQ[0] : 8'h00);
      end
      @(posedge clk);
      #1;
      pop = (fifoQ.size() != 0) && txReady;
      if (pop) void'(fifoQ.pop_front());
      if (isPush) begin
        if (fifoQ.size() < Depth) fifoQ.push_back(wd[7:0]);
        else errM[1] = 1'b1;
      end
      if (op <= 5) begin
        n = sizeBytes(sz);
        if ((a % n) != 0) errM[0] = 1'b1;
        else if (wen) for (int b = 0; b < n; b++) memM[int'(a) + b] = wd[8*b +: 8];
      end
      setIdle();
    end
    txReady = 1'b0;
    nChecks++; if (errSticky !== errM) begin nFails++; $display("FAIL rand_err: got %b expected %b", errSticky, errM); end
  endtask

  initial begin
    rst = 1'b1;
    txReady = 1'b0;
    errM = 2'b00;
    haltM = 1'b0;
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_ext();
    test_half_store();
    test_fifo_overflow();
    test_full_pop_push();
    test_counter();
    test_halt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
